// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: shadow pipeline of in-flight destination tags that drives the EX forwarding
// selects, the load-use stall and a saturating stall counter
module fwd_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1),
    parameter int CNT_W      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_id_valid,
    input  logic [NUM_SRC*5-1:0]     i_id_src,
    input  logic [NUM_SRC-1:0]       i_id_src_used,
    input  logic [4:0]               i_id_dst,
    input  logic                     i_id_wen,
    input  logic                     i_id_is_load,
    input  logic                     i_freeze,
    input  logic                     i_flush,
    output logic                     o_stall,
    output logic [NUM_SRC*SEL_W-1:0] o_fwd_sel,
    output logic [CNT_W-1:0]         o_stall_cnt
);

    logic [DEPTH-1:0]         r_v;
    logic [DEPTH-1:0]         r_wen;
    logic [DEPTH-1:0]         r_ld;
    logic [4:0]               r_dst [DEPTH];
    logic [NUM_SRC*SEL_W-1:0] r_sel;
    logic [CNT_W-1:0]         r_cnt;
    logic [NUM_SRC*SEL_W-1:0] w_sel;
    logic [NUM_SRC-1:0]       w_hzd;
    logic                     w_enter;

    // Per source, scan oldest to youngest so the youngest matching slot overwrites the result
    always_comb begin
        w_sel = '0;
        w_hzd = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (r_v[k] && r_wen[k] && r_dst[k] != 5'd0 &&
                    r_dst[k] == i_id_src[5*s +: 5] && i_id_src_used[s]) begin
                    w_sel[s*SEL_W +: SEL_W] = (k + 1 >= DEPTH) ? '0 : SEL_W'(k + 1);
                    w_hzd[s] = r_ld[k] && (k + 1 < DEPTH) && (k + 1 < LOAD_READY);
                end
            end
        end
    end

    assign o_stall     = i_id_valid & ~i_flush & (|w_hzd);
    assign w_enter     = i_id_valid & ~o_stall & ~i_flush;
    assign o_fwd_sel   = r_sel;
    assign o_stall_cnt = r_cnt;

    // Advance the tag pipeline one stage per unfrozen cycle; a stalled or flushed ID enters as a bubble
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v   <= '0;
            r_wen <= '0;
            r_ld  <= '0;
            for (int k = 0; k < DEPTH; k++) r_dst[k] <= '0;
        end else if (!i_freeze) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_v[k]   <= r_v[k-1];
                r_wen[k] <= r_wen[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_dst[k] <= r_dst[k-1];
            end
            r_v[0]   <= w_enter;
            r_wen[0] <= i_id_wen;
            r_ld[0]  <= i_id_is_load;
            r_dst[0] <= i_id_dst;
        end
    end

    // Register the selects into EX alongside the instruction; bubbles read the regfile
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sel <= '0;
        else if (!i_freeze) r_sel <= w_enter ? w_sel : '0;
    end

    // Count real stall cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_cnt <= '0;
        else if (!i_freeze && o_stall && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end

endmodule
